// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared constants and lane indexing for the 3x3 rank filter
package median_pkg;

  localparam logic [1:0] MODE_MEDIAN = 2'd0;
  localparam logic [1:0] MODE_MIN    = 2'd1;
  localparam logic [1:0] MODE_MAX    = 2'd2;
  localparam logic [1:0] MODE_BYPASS = 2'd3;

  localparam int PIPE_DEPTH = 3;

  // Lane positions within a 3-lane sorted triple (logic [2:0][DW-1:0]).
  typedef enum logic [1:0] {
    LANE_LO = 2'd0,
    LANE_MD = 2'd1,
    LANE_HI = 2'd2
  } lane_e;

endpackage

// File: rtl/median_filter_stream_sort3.sv
// rtl/median_filter_stream_sort3.sv - combinational unsigned 3-input sorter
module sort3_w #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] md,
  output logic [DW-1:0] hi
);

  logic [DW-1:0] x_lo;
  logic [DW-1:0] x_hi;

  always_comb begin
    x_lo = (a <= b) ? a : b;
    x_hi = (a <= b) ? b : a;
    lo   = x_lo;
    md   = x_hi;
    hi   = c;
    if (c < x_lo) begin
      lo = c;
      md = x_lo;
      hi = x_hi;
    end else if (c < x_hi) begin
      md = c;
      hi = x_hi;
    end
  end

endmodule

// File: rtl/median_filter_stream.sv
// rtl/median_filter_stream.sv - streaming 3x3 rank filter (median/min/max/bypass)
// with two line buffers, column history and a 3-stage sort pipeline.
module median_filter_stream
  import median_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sof,
  input  logic [1:0]    mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sof,
  output logic          out_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];

  logic [CW-1:0] col, ecol;
  logic [RW-1:0] row, erow;
  logic          synced;
  logic [1:0]    mode_r;
  logic          stall, acc, win_ok;
  logic [PIPE_DEPTH-1:0] vld;

  // Only the two newest window columns are stored; the incoming column completes the window.
  logic [2:0][DW-1:0]       cw0, cw1, ncol;
  logic [2:0][2:0][DW-1:0]  wnext, s1_n, s1_q;
  logic [DW-1:0]            s1_ctr;
  logic                     s1_sof, s1_eof;
  logic [1:0]               s1_mode;

  logic [DW-1:0] min_of_lo, max_of_lo, mid_of_md, min_of_hi, max_of_hi;
  logic [DW-1:0] unused_mid_of_lo, unused_min_of_md, unused_max_of_md, unused_mid_of_hi;
  logic [2:0][DW-1:0] s2_tri;
  logic [DW-1:0]      s2_min, s2_max, s2_ctr;
  logic               s2_sof, s2_eof;
  logic [1:0]         s2_mode;

  logic [DW-1:0] med, unused_s3_lo, unused_s3_hi, sel_data;

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign acc       = in_valid && in_ready;
  assign out_valid = vld[PIPE_DEPTH-1];

  assign ecol   = in_sof ? '0 : col;
  assign erow   = in_sof ? '0 : row;
  assign ncol   = {lb1[ecol], lb0[ecol], in_data};
  assign wnext  = {ncol, cw1, cw0};
  assign win_ok = acc && synced && !in_sof && (erow >= RW'(2)) && (ecol >= CW'(2));

  for (genvar k = 0; k < 3; k++) begin : g_col
    sort3_w #(.DW(DW)) u_col (
      .a(wnext[k][0]), .b(wnext[k][1]), .c(wnext[k][2]),
      .lo(s1_n[k][LANE_LO]), .md(s1_n[k][LANE_MD]), .hi(s1_n[k][LANE_HI])
    );
  end

  sort3_w #(.DW(DW)) u_s2_lo (
    .a(s1_q[0][LANE_LO]), .b(s1_q[1][LANE_LO]), .c(s1_q[2][LANE_LO]),
    .lo(min_of_lo), .md(unused_mid_of_lo), .hi(max_of_lo)
  );
  sort3_w #(.DW(DW)) u_s2_md (
    .a(s1_q[0][LANE_MD]), .b(s1_q[1][LANE_MD]), .c(s1_q[2][LANE_MD]),
    .lo(unused_min_of_md), .md(mid_of_md), .hi(unused_max_of_md)
  );
  sort3_w #(.DW(DW)) u_s2_hi (
    .a(s1_q[0][LANE_HI]), .b(s1_q[1][LANE_HI]), .c(s1_q[2][LANE_HI]),
    .lo(min_of_hi), .md(unused_mid_of_hi), .hi(max_of_hi)
  );
  sort3_w #(.DW(DW)) u_s3 (
    .a(s2_tri[LANE_LO]), .b(s2_tri[LANE_MD]), .c(s2_tri[LANE_HI]),
    .lo(unused_s3_lo), .md(med), .hi(unused_s3_hi)
  );

  always_comb begin
    sel_data = med;
    case (s2_mode)
      MODE_MIN:    sel_data = s2_min;
      MODE_MAX:    sel_data = s2_max;
      MODE_BYPASS: sel_data = s2_ctr;
      default:     sel_data = med;
    endcase
  end

  // Datapath registers carry no reset; their contents are qualified by vld.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb0[ecol] <= in_data;
      lb1[ecol] <= lb0[ecol];
      cw0       <= cw1;
      cw1       <= ncol;
    end
    if (!stall) begin
      s1_q    <= s1_n;
      s1_ctr  <= cw1[1];
      s1_sof  <= (erow == RW'(2)) && (ecol == CW'(2));
      s1_eof  <= (erow == LAST_ROW) && (ecol == LAST_COL);
      s1_mode <= mode_r;
      s2_tri[LANE_LO] <= max_of_lo;
      s2_tri[LANE_MD] <= mid_of_md;
      s2_tri[LANE_HI] <= min_of_hi;
      s2_min  <= min_of_lo;
      s2_max  <= max_of_hi;
      s2_ctr  <= s1_ctr;
      s2_sof  <= s1_sof;
      s2_eof  <= s1_eof;
      s2_mode <= s1_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row      <= '0;
      col      <= '0;
      synced   <= 1'b0;
      mode_r   <= MODE_MEDIAN;
      vld      <= '0;
      out_data <= '0;
      out_sof  <= 1'b0;
      out_eof  <= 1'b0;
    end else begin
      if (acc) begin
        if (in_sof) begin
          synced <= 1'b1;
          mode_r <= mode;
        end
        if (ecol == LAST_COL) begin
          col <= '0;
          row <= (erow == LAST_ROW) ? '0 : erow + 1'b1;
        end else begin
          col <= ecol + 1'b1;
          row <= erow;
        end
      end
      if (!stall) begin
        vld <= {vld[PIPE_DEPTH-2:0], win_ok};
        if (vld[PIPE_DEPTH-2]) begin
          out_data <= sel_data;
          out_sof  <= s2_sof;
          out_eof  <= s2_eof;
        end else begin
          out_sof  <= 1'b0;
          out_eof  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_median_filter_stream.sv
// tb/tb_median_filter_stream.sv - scoreboard bench: 4x4 and 5x5 instances checked
// against a whole-image rank model.
module tb_median_filter_stream;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, sel, bp;
  logic          in_valid, in_sof, out_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    mode;
  logic          ir4, ir5, ov4, ov5, os4, os5, oe4, oe5;
  logic [DW-1:0] od4, od5;
  logic          ir_m, ov_m, os_m, oe_m;
  logic [DW-1:0] od_m;

  median_filter_stream #(.DW(DW), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(ir4), .in_data(in_data),
    .in_sof(in_sof), .mode(mode), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .out_sof(os4), .out_eof(oe4)
  );
  median_filter_stream #(.DW(DW), .IMG_W(5), .IMG_H(5)) u5 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(ir5), .in_data(in_data),
    .in_sof(in_sof), .mode(mode), .out_valid(ov5), .out_ready(out_ready),
    .out_data(od5), .out_sof(os5), .out_eof(oe5)
  );

  assign ir_m = sel ? ir5 : ir4;
  assign ov_m = sel ? ov5 : ov4;
  assign od_m = sel ? od5 : od4;
  assign os_m = sel ? os5 : os4;
  assign oe_m = sel ? oe5 : oe4;

  typedef struct {
    int data;
    bit sof;
    bit eof;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc_cyc, acc10, first_ov;
  int   img [5][5];
  int   m_r, m_c, m_w, m_h, m_mode;
  bit   m_sync;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
  end

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: keep the frame as an image; each interior-completing pixel ranks its 3x3 neighbourhood.
  task automatic model_accept(int d, bit sof, int md);
    int   r, c, e;
    int   w[$];
    if (sof) begin
      m_r = 0; m_c = 0; m_sync = 1; m_mode = md;
    end
    r = m_r; c = m_c;
    img[r][c] = d;
    if (m_sync && r >= 2 && c >= 2) begin
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          w.push_back(img[r-2+dr][c-2+dc]);
      w.sort();
      case (m_mode)
        1:       e = w[0];
        2:       e = w[8];
        3:       e = img[r-1][c-1];
        default: e = w[4];
      endcase
      q.push_back('{e, (r == 2 && c == 2), (r == m_h - 1 && c == m_w - 1)});
    end
    m_c++;
    if (m_c == m_w) begin
      m_c = 0;
      m_r++;
      if (m_r == m_h) m_r = 0;
    end
  endtask

  task automatic send(int d, bit sof, int md, bit gaps);
    int budget = 0;
    bit ok = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = 8'(d);
    in_sof   = sof;
    mode     = sof ? 2'(md) : 2'($urandom_range(0, 3));
    while (!ok && budget < 100) begin
      @(negedge clk);
      if (ir_m) ok = 1;
      else budget++;
    end
    if (ok) begin
      last_acc_cyc = cyc;
      model_accept(d, sof, md);
    end else begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stuck low, pixel %0d", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // kind: 0 ramp, 1 random, 2 impulse at (2,2)
  task automatic send_frame(int md, int kind, bit gaps);
    int d;
    for (int i = 0; i < m_w * m_h; i++) begin
      d = (kind == 0) ? i : (kind == 1) ? int'($urandom_range(0, 255)) :
          ((i == 2 * m_w + 2) ? 255 : 50);
      send(d, i == 0, md, gaps);
      if (i == 10) acc10 = last_acc_cyc;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d outputs missing, expected 0", q.size());
      q.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    m_sync = 0; m_r = 0; m_c = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  bit            stall_prev = 0;
  logic [DW-1:0] held_d;
  logic          held_s, held_e;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (ov_m && first_ov < 0) first_ov = cyc;
      if (stall_prev) begin
        total++;
        if (!(ov_m && od_m == held_d && os_m == held_s && oe_m == held_e)) begin
          bad++;
          $display("FAIL stall_hold: got v=%0b d=%0d s=%0b e=%0b expected v=1 d=%0d s=%0b e=%0b",
                   ov_m, od_m, os_m, oe_m, held_d, held_s, held_e);
        end
      end
      stall_prev = 0;
      if (ov_m && !out_ready) begin
        total++;
        if (ir_m !== 1'b0) begin
          bad++;
          $display("FAIL in_ready_stall: got %0b expected 0", ir_m);
        end
        stall_prev = 1;
        held_d = od_m; held_s = os_m; held_e = oe_m;
      end
      if (ov_m && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got data %0d, expected no output", od_m);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (int'(od_m) != e.data || os_m != e.sof || oe_m != e.eof) begin
            bad++;
            $display("FAIL output: got d=%0d sof=%0b eof=%0b expected d=%0d sof=%0b eof=%0b",
                     od_m, os_m, oe_m, e.data, e.sof, e.eof);
          end
        end
      end
    end
  end

  initial begin
    sel = 0; bp = 0; in_valid = 0; in_sof = 0; in_data = '0; mode = '0;
    rst = 1; first_ov = -1; acc10 = 0; last_acc_cyc = 0;
    m_w = 4; m_h = 4; m_sync = 0; m_r = 0; m_c = 0; m_mode = 0;
    repeat (3) @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("reset_out_valid", ov4, 0);
    chk("reset_out_data", od4, 0);
    chk("reset_out_sof", os4, 0);
    chk("reset_out_eof", oe4, 0);
    chk("reset_in_ready", ir4, 1);
    chk("reset_in_ready_5x5", ir5, 1);

    // Pixels before any sof are discarded.
    for (int i = 0; i < 20; i++) send($urandom_range(0, 255), 0, 0, 0);
    drain();

    first_ov = -1;
    send_frame(0, 0, 0);
    chk("latency", first_ov - acc10, 3);
    drain();
    for (int m = 1; m < 4; m++) begin
      send_frame(m, 0, 0);
      drain();
    end

    bp = 1;
    send_frame(0, 0, 1);
    for (int k = 0; k < 4; k++) send_frame($urandom_range(0, 3), 1, 1);
    drain();
    bp = 0;

    // Resync: a partial frame is cut short by a new sof.
    for (int i = 0; i < 6; i++) send(i, i == 0, 0, 0);
    send_frame(0, 0, 0);
    drain();

    // Reset with a window in flight.
    for (int i = 0; i < 11; i++) send(i, i == 0, 0, 0);
    do_reset();
    @(negedge clk);
    chk("midreset_out_valid", ov4, 0);
    chk("midreset_in_ready", ir4, 1);
    for (int i = 0; i < 5; i++) send($urandom_range(0, 255), 0, 0, 0);
    send_frame(2, 0, 0);
    drain();

    sel = 1; m_w = 5; m_h = 5; m_sync = 0; m_r = 0; m_c = 0;
    send_frame(0, 2, 0);
    drain();
    send_frame(2, 2, 0);
    drain();
    bp = 1;
    send_frame($urandom_range(0, 3), 1, 1);
    send_frame(3, 1, 1);
    drain();
    bp = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
